// File: rtl/core_pkg.sv
// Definitions shared by the instruction encoder and the immediate generator:
// instruction formats, base opcodes and the canonical NOP.
package core_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_LI  = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LW        = 7'b0000011;
  localparam logic [6:0] OPC_SW        = 7'b0100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_IMMEDIATE = 7'b0010011;

  localparam logic [31:0] ERR_NOP_DEFAULT = 32'h00000013;

  // True when v is reachable by sign-extending its own low 12 bits.
  function automatic logic fits_s12(input logic [31:0] v);
    return v == {{20{v[11]}}, v[11:0]};
  endfunction

endpackage

// File: rtl/instruction_field_packer.sv
// Combinational RV32I field packer with immediate range check; any failure
// replaces the word with ERR_NOP.
module instruction_field_packer import core_pkg::*; #(
  parameter logic [31:0] ERR_NOP = ERR_NOP_DEFAULT
) (
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic [31:0] raw;
  logic        bad;
  logic        is_shift;

  assign is_shift = (opcode == OPC_IMMEDIATE) && (funct3 == 3'b001 || funct3 == 3'b101);

  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift) begin
          bad = imm[31:5] != '0;
          raw = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        end else begin
          bad = !fits_s12(imm);
          raw = {imm[11:0], rs1, funct3, rd, opcode};
        end
      end
      FMT_S: begin
        bad = !fits_s12(imm);
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_U: begin
        bad = imm[11:0] != '0;
        raw = {imm[31:12], rd, opcode};
      end
      FMT_J: begin
        bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      // LI must be lowered by the caller; reaching here means it is disabled.
      default: bad = 1'b1;
    endcase
    err  = bad;
    word = bad ? ERR_NOP : raw;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Registered RV32I instruction encoder with valid/ready on both sides; lowers
// the LI pseudo-op to ADDI, LUI or a LUI+ADDI pair.
module instruction_encoder import core_pkg::*; #(
  parameter bit          LI_ENABLE = 1'b1,
  parameter logic [31:0] ERR_NOP   = ERR_NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic {ST_IDLE, ST_LI_ADDI} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;
  logic [4:0]  li_rd_q, li_rd_d;
  logic [11:0] li_lo_q, li_lo_d;

  logic [2:0]  p_fmt, p_funct3;
  logic [6:0]  p_opcode, p_funct7;
  logic [4:0]  p_rd, p_rs1, p_rs2;
  logic [31:0] p_imm, p_word;
  logic        p_err;

  logic        is_li, li_fits, li_two;
  logic [19:0] li_hi;
  logic        accept, consume;

  assign is_li   = LI_ENABLE && (req_fmt == FMT_LI);
  assign li_fits = fits_s12(req_imm);
  assign li_two  = is_li && !li_fits && (req_imm[11:0] != '0);
  // Rounded upper part so that the sign-extended ADDI lands on the target.
  assign li_hi   = req_imm[31:12] + {19'd0, req_imm[11]};

  assign req_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = req_valid && req_ready;
  assign consume   = out_valid_q && out_ready;

  always_comb begin
    p_fmt    = req_fmt;
    p_opcode = req_opcode;
    p_rd     = req_rd;
    p_rs1    = req_rs1;
    p_rs2    = req_rs2;
    p_funct3 = req_funct3;
    p_funct7 = req_funct7;
    p_imm    = req_imm;
    if (state_q == ST_LI_ADDI) begin
      p_fmt    = FMT_I;
      p_opcode = OPC_IMMEDIATE;
      p_rd     = li_rd_q;
      p_rs1    = li_rd_q;
      p_rs2    = '0;
      p_funct3 = 3'b000;
      p_funct7 = '0;
      p_imm    = {{20{li_lo_q[11]}}, li_lo_q};
    end else if (is_li) begin
      p_rs1    = '0;
      p_rs2    = '0;
      p_funct3 = 3'b000;
      p_funct7 = '0;
      if (li_fits) begin
        p_fmt    = FMT_I;
        p_opcode = OPC_IMMEDIATE;
      end else begin
        p_fmt    = FMT_U;
        p_opcode = OPC_LUI;
        p_imm    = {li_hi, 12'd0};
      end
    end
  end

  instruction_field_packer #(.ERR_NOP(ERR_NOP)) u_packer (
    .fmt(p_fmt), .opcode(p_opcode), .rd(p_rd), .rs1(p_rs1), .rs2(p_rs2),
    .funct3(p_funct3), .funct7(p_funct7), .imm(p_imm), .word(p_word), .err(p_err)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    li_rd_d     = li_rd_q;
    li_lo_d     = li_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = p_word;
          out_err_d   = p_err;
          out_last_d  = !li_two;
          if (li_two) begin
            state_d = ST_LI_ADDI;
            li_rd_d = req_rd;
            li_lo_d = req_imm[11:0];
          end
        end else if (consume) begin
          out_valid_d = 1'b0;
        end
      end
      ST_LI_ADDI: begin
        if (consume) begin
          out_instr_d = p_word;
          out_err_d   = p_err;
          out_last_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      li_rd_q     <= '0;
      li_lo_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      li_rd_q     <= li_rd_d;
      li_lo_q     <= li_lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed scenarios plus a randomized run
// scored against an arithmetic model of the RV32I encodings.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_fmt = '0;
  logic [6:0]  req_opcode = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid, out_ready = 1'b1, out_last, out_err;
  logic [31:0] out_instr;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_opcode(req_opcode), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
    .req_funct7(req_funct7), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .out_err(out_err)
  );

  function automatic void push_beat(input logic [31:0] w, input logic last, input logic err);
    beat_t b;
    b.instr = w; b.last = last; b.err = err;
    exp_q.push_back(b);
  endfunction

  // Reference: encodings built from field positions and numeric ranges.
  function automatic void model(input logic [2:0] f, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
    int          si;
    bit          ok;
    logic [31:0] w, base, hi;
    si   = $signed(imm);
    ok   = 1'b1;
    w    = 0;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    if (f == 3'd6) begin
      if (si >= -2048 && si <= 2047) begin
        push_beat(((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13, 1'b1, 1'b0);
      end else if ((imm & 32'hFFF) == 0) begin
        push_beat(imm | (32'(rd) << 7) | 32'h37, 1'b1, 1'b0);
      end else begin
        hi = (imm + 32'h800) & 32'hFFFFF000;
        push_beat(hi | (32'(rd) << 7) | 32'h37, 1'b0, 1'b0);
        push_beat(((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13, 1'b1, 1'b0);
      end
      return;
    end
    case (f)
      3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      3'd1: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          ok = imm < 32;
          w  = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | base | (32'(rd) << 7);
        end else begin
          ok = si >= -2048 && si <= 2047;
          w  = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
        end
      end
      3'd2: begin
        ok = si >= -2048 && si <= 2047;
        w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
      end
      3'd3: begin
        ok = si >= -4096 && si <= 4095 && (imm % 2) == 0;
        w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
             base | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      end
      3'd4: begin
        ok = (imm & 32'hFFF) == 0;
        w  = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      3'd5: begin
        ok = si >= -1048576 && si <= 1048575 && (imm % 2) == 0;
        w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
      end
      default: ok = 1'b0;
    endcase
    if (ok) push_beat(w, 1'b1, 1'b0);
    else    push_beat(32'h00000013, 1'b1, 1'b1);
  endfunction

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    req_fmt = f; req_opcode = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_funct3 = f3; req_funct7 = f7; req_imm = imm;
  endtask

  // One-cycle request pulse; caller ensures the encoder is idle.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    @(negedge clk);
    set_req(f, op, rd, rs1, rs2, f3, f7, imm);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr} !== 35'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v%b l%b e%b %h, want all zero", out_valid, out_last, out_err, out_instr);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_i_addi();
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr} !== {3'b110, 32'hFFF30293}) begin
      n_fail++; $display("FAIL addi: got v%b l%b e%b %h want 1 1 0 fff30293", out_valid, out_last, out_err, out_instr);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_branch();
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    n_vec++;
    if ({out_valid, out_err, out_instr} !== {2'b10, 32'h00208463}) begin
      n_fail++; $display("FAIL beq8: got v%b e%b %h want 1 0 00208463", out_valid, out_err, out_instr);
    end
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr} !== {3'b111, 32'h00000013}) begin
      n_fail++; $display("FAIL beq_odd: got v%b l%b e%b %h want 1 1 1 00000013", out_valid, out_last, out_err, out_instr);
    end
  endtask

  task automatic test_li_two_beat();
    send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr, req_ready} !== {3'b100, 32'h12346537, 1'b0}) begin
      n_fail++; $display("FAIL li_lui: got v%b l%b e%b %h rdy%b want 1 0 0 12346537 rdy0", out_valid, out_last, out_err, out_instr, req_ready);
    end
    @(negedge clk);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr} !== {3'b110, 32'hFFF50513}) begin
      n_fail++; $display("FAIL li_addi: got v%b l%b e%b %h want 1 1 0 fff50513", out_valid, out_last, out_err, out_instr);
    end
    @(negedge clk);
  endtask

  task automatic test_li_single();
    send(3'd6, 7'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr} !== {3'b110, 32'h7FF00093}) begin
      n_fail++; $display("FAIL li_small: got v%b l%b e%b %h want 1 1 0 7ff00093", out_valid, out_last, out_err, out_instr);
    end
    send(3'd6, 7'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr} !== {3'b110, 32'h000010B7}) begin
      n_fail++; $display("FAIL li_lui_only: got v%b l%b e%b %h want 1 1 0 000010b7", out_valid, out_last, out_err, out_instr);
    end
    send(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32);
    n_vec++;
    if ({out_valid, out_err, out_instr} !== {2'b11, 32'h00000013}) begin
      n_fail++; $display("FAIL slli32: got v%b e%b %h want 1 1 00000013", out_valid, out_err, out_instr);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd100);
    set_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({out_valid, out_last, out_err, out_instr, req_ready} !== {3'b110, 32'h06420193, 1'b0}) begin
        n_fail++; $display("FAIL stall_%0d: got v%b l%b e%b %h rdy%b want 1 1 0 06420193 rdy0", i, out_valid, out_last, out_err, out_instr, req_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_instr} !== {1'b1, 32'h002081B3}) begin
      n_fail++; $display("FAIL stall_next: got v%b %h want 1 002081b3", out_valid, out_instr);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_li();
    out_ready = 1'b1;
    send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    @(negedge clk);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, out_instr} !== 33'd0) begin
      n_fail++; $display("FAIL async_reset: got v%b %h want 0 00000000", out_valid, out_instr);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_drop_addi: got v%b rdy%b want v0 rdy1", out_valid, req_ready);
    end
    send(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    n_vec++;
    if ({out_valid, out_last, out_err, out_instr} !== {3'b110, 32'hFFF30293}) begin
      n_fail++; $display("FAIL post_reset_addi: got v%b l%b e%b %h want 1 1 0 fff30293", out_valid, out_last, out_err, out_instr);
    end
    @(negedge clk);
  endtask

  task automatic rand_req();
    logic [31:0] imm;
    case ($urandom_range(0, 4))
      0: imm = 32'($urandom_range(0, 40));
      1: imm = $urandom;
      2: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      3: imm = $urandom & 32'hFFFFF000;
      default: imm = 32'($urandom_range(0, 2097152)) - 32'd1048576;
    endcase
    set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), imm);
    if ($urandom_range(0, 3) == 0) begin
      req_opcode = 7'h13;
      req_funct3 = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
    end
  endtask

  task automatic test_back_to_back();
    bit acc = 1'b0;
    int guard;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (acc) req_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid && $urandom_range(0, 4) != 0) begin
        rand_req();
        req_valid = 1'b1;
      end
      #1;
      n_vec++;
      if (req_ready !== (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready))) begin
        n_fail++; $display("FAIL rnd_ready cyc%0d: got %b with %0d beats queued", cyc, req_ready, exp_q.size());
      end
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra cyc%0d: unexpected beat %h", cyc, out_instr);
        end else begin
          if ({out_instr, out_last, out_err} !== {exp_q[0].instr, exp_q[0].last, exp_q[0].err}) begin
            n_fail++; $display("FAIL rnd_beat cyc%0d: got %h l%b e%b want %h l%b e%b", cyc, out_instr, out_last, out_err, exp_q[0].instr, exp_q[0].last, exp_q[0].err);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        n_vec++; n_fail++;
        $display("FAIL rnd_missing cyc%0d: out_valid 0 with %0d beats queued", cyc, exp_q.size());
      end
      acc = req_valid && req_ready;
      if (acc) model(req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm);
    end
    @(negedge clk);
    if (acc) req_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      #1;
      if (out_valid) begin
        n_vec++;
        if ({out_instr, out_last, out_err} !== {exp_q[0].instr, exp_q[0].last, exp_q[0].err}) begin
          n_fail++; $display("FAIL rnd_drain: got %h l%b e%b want %h l%b e%b", out_instr, out_last, out_err, exp_q[0].instr, exp_q[0].last, exp_q[0].err);
        end
        void'(exp_q.pop_front());
      end
      guard++;
      @(negedge clk);
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_timeout: %0d beats never delivered", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_i_addi();
    test_branch();
    test_li_two_beat();
    test_li_single();
    test_backpressure();
    test_reset_mid_li();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
